// File: rtl/prefix_emitter.sv
// Serializes one decoded x86 instruction (legacy prefixes, then opcode bytes)
// into a byte stream, one byte per valid/ready handshake.
module prefix_emitter #(
    parameter int unsigned OPC_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   seg_en,
    input  logic [2:0]             seg_id,
    input  logic                   opsz_en,
    input  logic                   rep_en,
    input  logic [2:0]             opc_len,
    input  logic [8*OPC_BYTES-1:0] opc_bytes,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   out_is_prefix,
    output logic                   out_last,
    output logic                   err_seg
);
    localparam int unsigned LW = $clog2(OPC_BYTES + 1);

    typedef enum logic [2:0] {IDLE, SEG, OPSZ, REP, OPC} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             seg_byte_q, seg_byte_d;
    logic                   seg_ok_q, seg_ok_d;
    logic                   opsz_q, opsz_d;
    logic                   rep_q, rep_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          idx_q, idx_d;
    logic [8*OPC_BYTES-1:0] opc_q, opc_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_byte_q, out_byte_d;
    logic                   out_is_prefix_q, out_is_prefix_d;
    logic                   out_last_q, out_last_d;
    logic                   err_seg_q, err_seg_d;

    logic accept, hs, is_last;

    // First enabled state strictly after s, in fixed order SEG, OPSZ, REP, OPC.
    function automatic state_t next_after(state_t s, logic seg, logic opsz, logic rep);
        if (s == IDLE && seg) return SEG;
        if ((s == IDLE || s == SEG) && opsz) return OPSZ;
        if (s != REP && rep) return REP;
        return OPC;
    endfunction

    function automatic logic [7:0] seg_code(logic [2:0] id);
        case (id)
            3'b000:  return 8'h26;
            3'b001:  return 8'h2E;
            3'b010:  return 8'h36;
            3'b011:  return 8'h3E;
            3'b100:  return 8'h64;
            3'b101:  return 8'h65;
            default: return 8'h00;
        endcase
    endfunction

    assign is_last   = (idx_q + LW'(1)) == len_q;
    assign hs        = out_valid_q & out_ready;
    assign cmd_ready = rst_n & ((state_q == IDLE) | ((state_q == OPC) & is_last & out_ready));
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d    = state_q;
        seg_byte_d = seg_byte_q;
        seg_ok_d   = seg_ok_q;
        opsz_d     = opsz_q;
        rep_d      = rep_q;
        len_d      = len_q;
        idx_d      = idx_q;
        opc_d      = opc_q;
        err_seg_d  = 1'b0;

        if (accept) begin
            seg_byte_d = seg_code(seg_id);
            seg_ok_d   = seg_en & (seg_id < 3'd6);
            err_seg_d  = seg_en & (seg_id >= 3'd6);
            opsz_d     = opsz_en;
            rep_d      = rep_en;
            opc_d      = opc_bytes;
            idx_d      = '0;
            if (opc_len == 3'd0)
                len_d = LW'(1);
            else if (32'(opc_len) > OPC_BYTES)
                len_d = LW'(OPC_BYTES);
            else
                len_d = LW'(opc_len);
            state_d = next_after(IDLE, seg_ok_d, opsz_d, rep_d);
        end else if (hs) begin
            if (state_q == OPC) begin
                if (is_last) state_d = IDLE;
                else         idx_d   = idx_q + LW'(1);
            end else begin
                state_d = next_after(state_q, seg_ok_q, opsz_q, rep_q);
            end
        end

        // Outputs are precomputed from the next state so they appear registered.
        out_valid_d     = (state_d != IDLE);
        out_is_prefix_d = (state_d == SEG) || (state_d == OPSZ) || (state_d == REP);
        out_last_d      = (state_d == OPC) && ((idx_d + LW'(1)) == len_d);
        out_byte_d      = '0;
        case (state_d)
            SEG:  out_byte_d = seg_byte_d;
            OPSZ: out_byte_d = 8'h66;
            REP:  out_byte_d = 8'hF2;
            OPC: begin
                for (int unsigned i = 0; i < OPC_BYTES; i++)
                    if (LW'(i) == idx_d) out_byte_d = opc_d[8*i +: 8];
            end
            default: out_byte_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            seg_byte_q      <= '0;
            seg_ok_q        <= 1'b0;
            opsz_q          <= 1'b0;
            rep_q           <= 1'b0;
            len_q           <= '0;
            idx_q           <= '0;
            opc_q           <= '0;
            out_valid_q     <= 1'b0;
            out_byte_q      <= '0;
            out_is_prefix_q <= 1'b0;
            out_last_q      <= 1'b0;
            err_seg_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            seg_byte_q      <= seg_byte_d;
            seg_ok_q        <= seg_ok_d;
            opsz_q          <= opsz_d;
            rep_q           <= rep_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            opc_q           <= opc_d;
            out_valid_q     <= out_valid_d;
            out_byte_q      <= out_byte_d;
            out_is_prefix_q <= out_is_prefix_d;
            out_last_q      <= out_last_d;
            err_seg_q       <= err_seg_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_byte      = out_byte_q;
    assign out_is_prefix = out_is_prefix_q;
    assign out_last      = out_last_q;
    assign err_seg       = err_seg_q;

endmodule

// File: tb/tb_prefix_emitter.sv
// Directed bench for prefix_emitter: expected bytes are queued at command
// issue and compared against each output handshake.
module tb_prefix_emitter;
    localparam int unsigned OPC_BYTES = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   seg_en;
    logic [2:0]             seg_id;
    logic                   opsz_en;
    logic                   rep_en;
    logic [2:0]             opc_len;
    logic [8*OPC_BYTES-1:0] opc_bytes;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_byte;
    logic                   out_is_prefix;
    logic                   out_last;
    logic                   err_seg;

    int compared   = 0;
    int mismatched = 0;

    // Entry layout: {byte, is_prefix, last}
    logic [9:0] sb[$];

    prefix_emitter #(.OPC_BYTES(OPC_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .seg_en       (seg_en),
        .seg_id       (seg_id),
        .opsz_en      (opsz_en),
        .rep_en       (rep_en),
        .opc_len      (opc_len),
        .opc_bytes    (opc_bytes),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .out_is_prefix(out_is_prefix),
        .out_last     (out_last),
        .err_seg      (err_seg)
    );

    always #5 clk = ~clk;

    // Handshake monitor: sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $error("FAIL unexpected_byte observed=%h expected=none", out_byte);
            end else begin
                logic [9:0] exp;
                exp = sb.pop_front();
                assert ({out_byte, out_is_prefix, out_last} === exp) else begin
                    mismatched++;
                    $error("FAIL stream_byte observed=%h/p%0b/l%0b expected=%h/p%0b/l%0b",
                           out_byte, out_is_prefix, out_last, exp[9:2], exp[1], exp[0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input logic se, input logic [2:0] sid, input logic os,
                              input logic rp, input logic [2:0] len,
                              input logic [8*OPC_BYTES-1:0] b);
        logic [7:0] sc;
        int n;
        case (sid)
            3'd0: sc = 8'h26;
            3'd1: sc = 8'h2E;
            3'd2: sc = 8'h36;
            3'd3: sc = 8'h3E;
            3'd4: sc = 8'h64;
            3'd5: sc = 8'h65;
            default: sc = 8'h00;
        endcase
        if (se && sid < 3'd6) sb.push_back({sc, 1'b1, 1'b0});
        if (os) sb.push_back({8'h66, 1'b1, 1'b0});
        if (rp) sb.push_back({8'hF2, 1'b1, 1'b0});
        n = (len == 0) ? 1 : ((int'(len) > OPC_BYTES) ? OPC_BYTES : int'(len));
        for (int i = 0; i < n; i++)
            sb.push_back({b[8*i +: 8], 1'b0, (i == n - 1)});
    endtask

    task automatic set_cmd(input logic se, input logic [2:0] sid, input logic os,
                           input logic rp, input logic [2:0] len,
                           input logic [8*OPC_BYTES-1:0] b);
        seg_en = se; seg_id = sid; opsz_en = os; rep_en = rp;
        opc_len = len; opc_bytes = b; cmd_valid = 1'b1;
        expect_cmd(se, sid, os, rp, len, b);
    endtask

    // Returns 1 ns after the accepting edge, with cmd_valid dropped.
    task automatic send(input logic se, input logic [2:0] sid, input logic os,
                        input logic rp, input logic [2:0] len,
                        input logic [8*OPC_BYTES-1:0] b);
        int waited;
        set_cmd(se, sid, os, rp, len, b);
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            compared++; mismatched++;
            $error("FAIL accept_timeout observed=%0d expected=<50", waited);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        seg_en = 1'b0; seg_id = 3'd0; opsz_en = 1'b0; rep_en = 1'b0;
        opc_len = 3'd0; opc_bytes = '1;
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sb.size() != 0) begin
            compared++; mismatched++;
            $error("FAIL %s_drain observed=%0d expected=0", tag, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        seg_en = 1'b0; seg_id = 3'd0; opsz_en = 1'b0; rep_en = 1'b0;
        opc_len = 3'd0; opc_bytes = '0;
        #1;
        check("rst_outs", {out_valid, out_is_prefix, out_last, err_seg, out_byte}, 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Full prefix set: 36 66 F2 0F AF
        send(1'b1, 3'b010, 1'b1, 1'b1, 3'd2, 32'h0000AF0F);
        check("full_first_valid", 32'(out_valid), 32'd1);
        check("full_no_err", 32'(err_seg), 32'd0);
        drain("full");

        // Single opcode, no prefixes: last and cmd_ready together.
        out_ready = 1'b1;
        send(1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 32'h00000090);
        @(negedge clk);
        check("single_ready_on_last", {31'd0, cmd_ready}, {31'd0, out_last});
        check("single_cmd_ready", 32'(cmd_ready), 32'd1);
        drain("single");

        // Backpressure: FS prefix held for 4 cycles.
        out_ready = 1'b0;
        send(1'b1, 3'b100, 1'b0, 1'b0, 3'd1, 32'h000000A4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_hold", {21'd0, out_valid, out_byte, out_is_prefix, out_last},
                  {21'd0, 1'b1, 8'h64, 1'b1, 1'b0});
            @(posedge clk); #1;
            if (k == 2) out_ready = 1'b1;
        end
        drain("stall");

        // Invalid segment: suppressed prefix, err_seg pulse.
        send(1'b1, 3'b111, 1'b1, 1'b0, 3'd1, 32'h000000AD);
        check("err_seg_pulse", 32'(err_seg), 32'd1);
        @(posedge clk); #1;
        check("err_seg_clear", 32'(err_seg), 32'd0);
        drain("badseg");

        // Back-to-back: F2 A5 90 with no gap.
        set_cmd(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 32'h000000A5);
        @(posedge clk); #1;
        set_cmd(1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 32'h00000090);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_no_gap", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
            if (k == 1) cmd_valid = 1'b0;
        end
        check("b2b_consumed", 32'(sb.size()), 32'd0);
        drain("b2b");

        // Length edges.
        send(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'h44332211);
        drain("len0");
        send(1'b0, 3'd0, 1'b1, 1'b0, 3'd6, 32'h44332211);
        drain("len6");
        send(1'b1, 3'b101, 1'b0, 1'b0, 3'd3, 32'h00CCBBAA);
        drain("len3");

        // Reset during second byte.
        send(1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 32'h00002211);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_outs", {out_is_prefix, out_last, out_byte}, 32'd0);
        sb.pop_front();
        check("midrst_pending", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_quiet", 32'(out_valid), 32'd0);
        send(1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 32'h000000C3);
        drain("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/prefix_emitter.md
Name: prefix_emitter

Overview:
- Serializes one decoded x86 instruction back into its byte stream, one byte per cycle over a valid/ready handshake.
- Output is legacy prefix bytes first, then 1–OPC_BYTES opcode bytes.
- It is the encode-side counterpart of the prefix checker. Every prefix byte it emits classifies identically when fed back through the prefix checker, which is how it is used in decode loopback tests.

Parameters:
- OPC_BYTES, default 4: maximum opcode/trailing bytes per command. opc_bytes width is 8*OPC_BYTES.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  emitter can accept a command this cycle.
- seg_en  in  1  emit a segment override prefix.
- seg_id  in  3  segment: 000 ES=0x26, 001 CS=0x2E, 010 SS=0x36, 011 DS=0x3E, 100 FS=0x64, 101 GS=0x65.
- opsz_en  in  1  emit operand-size override 0x66.
- rep_en  in  1  emit repeat prefix 0xF2.
- opc_len  in  3  number of opcode bytes to emit.
- opc_bytes  in  8*OPC_BYTES  opcode bytes; [7:0] is emitted first.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream accepts out_byte.
- out_byte  out  8  emitted byte.
- out_is_prefix  out  1  out_byte is a prefix byte.
- out_last  out  1  final byte of the instruction.
- err_seg  out  1  one-cycle pulse: seg_en was set with seg_id of 110 or 111.

Behaviour:
- Reset (async, while rst_n=0):
  - State = IDLE.
  - out_valid, out_byte, out_is_prefix, out_last, err_seg = 0.
  - cmd_ready = 0 while rst_n is low.
- cmd_ready = 1 when:
  - state is IDLE, or
  - state is OPC and the current byte is the last byte and out_ready=1 (back-to-back, no bubble).
- Accept: a command is accepted when cmd_valid & cmd_ready. All command fields are latched on that edge; later input changes are ignored until the next accept.
- opc_len normalisation:
  - 0 is treated as 1.
  - Values above OPC_BYTES clamp to OPC_BYTES.
- Invalid segment: seg_en=1 with seg_id in {110,111}:
  - Segment prefix is suppressed.
  - err_seg = 1 on the cycle after accept.
  - The rest of the command proceeds normally.
- FSM states: IDLE, SEG, OPSZ, REP, OPC.
  - From accept, go to the first enabled state in the order SEG -> OPSZ -> REP -> OPC. Disabled or suppressed states are skipped.
  - Advance to the next enabled state only on the out_valid & out_ready handshake.
  - OPC holds a byte index 0..len-1 and increments on each handshake.
  - On the last OPC handshake: go to IDLE, or reload directly if a new command is accepted on the same edge.
- Outputs are registered:
  - The first byte is valid on the cycle after accept (latency 1).
  - Fully unstalled throughput is one byte per cycle.
- Stall: while out_valid & !out_ready, out_byte, out_is_prefix and out_last hold stable.
- out_is_prefix = 1 in SEG, OPSZ and REP; 0 in OPC.
- out_last = 1 only on the final OPC byte.
- Prefix order is always segment, operand-size, repeat, regardless of input order.
- Mid-instruction reset: outputs are forced to 0 immediately (async). After release, the emitter is in IDLE with no partial bytes replayed.

Test Plan:
- Full prefix set: seg_en=1 seg_id=010, opsz_en=1, rep_en=1, opc_len=2, opc_bytes[15:0]=0xAF0F, out_ready=1.
  -> out_byte 36,66,F2,0F,AF on cycles 1–5; out_is_prefix 1,1,1,0,0; out_last only on AF.
- No prefixes, opc_len=1, opc_bytes[7:0]=0x90.
  -> one byte 0x90, out_is_prefix=0, out_last=1, cmd_ready=1 on the same cycle.
- Backpressure: seg_en=1 seg_id=100, opc 0xA4, out_ready=0 for 3 cycles after first valid.
  -> 0x64 held stable 4 cycles, then A4 with last=1.
- Invalid segment: seg_en=1 seg_id=111, opsz_en=1, opc 0xAD.
  -> err_seg pulse on cycle 1; bytes 66,AD only.
- Back-to-back: two commands (rep+0xA5, then 0x90), cmd_valid held, out_ready=1.
  -> F2,A5,90 on consecutive cycles with no idle gap.
- Length edges and reset:
  - opc_len=0 -> one opcode byte.
  - opc_len=6 -> exactly 4 opcode bytes.
  - rst_n pulsed low during the second byte -> out_valid drops at once; the next command restarts cleanly.
